// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: requester, response and SPI-master signals of the arbiter.
interface spi_txn_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic [7:0]           spi_tx_byte;
  logic                 spi_tx_start;
  logic                 spi_tx_done;
  logic [7:0]           spi_rx_byte;
  logic                 busy;
  logic                 timeout_err;
  modport slave (
    input  req_valid, req_last, req_data, spi_tx_done, spi_rx_byte,
    output req_ready, grant, rsp_valid, rsp_data, spi_tx_byte, spi_tx_start, busy, timeout_err
  );
  modport master (
    output req_valid, req_last, req_data, spi_tx_done, spi_rx_byte,
    input  req_ready, grant, rsp_valid, rsp_data, spi_tx_byte, spi_tx_start, busy, timeout_err
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin, frame-locked sharing of one byte-wide SPI master
// among NUM_REQ requesters, with a watchdog against stalled masters or abandoned grants.
module spi_txn_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input logic clk,
  input logic rst,
  spi_txn_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, GRANTED, START, WAIT} state_t;
  state_t r_state, w_state_n;
  logic [NUM_REQ-1:0] r_grant, r_rsp_valid;
  logic [IW-1:0] r_ptr, r_gidx, w_win, w_ptr_n;
  logic [7:0] r_beat, r_wd, r_tx_byte, r_rsp_data;
  logic r_last, r_timeout;
  logic w_any, w_accept, w_done, w_tick, w_timeout, w_release;
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    // Scan offsets high to low so the nearest requester at or after the pointer wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IW'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    w_accept  = (r_state == GRANTED) && bus.req_valid[r_gidx];
    w_done    = (r_state == WAIT) && bus.spi_tx_done;
    w_tick    = ((r_state == GRANTED) && !w_accept) || ((r_state == WAIT) && !bus.spi_tx_done);
    w_timeout = w_tick && (r_wd == 8'(TIMEOUT - 1));
    w_release = w_timeout || (w_done && (r_last || r_beat == 8'(MAX_BURST)));
    w_state_n = r_state == IDLE  ? (w_any ? GRANTED : IDLE) :
                r_state == START ? WAIT :
                w_release        ? IDLE :
                w_accept         ? START :
                w_done           ? GRANTED : r_state;
    w_ptr_n   = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_beat      <= '0;
      r_wd        <= '0;
      r_tx_byte   <= '0;
      r_rsp_data  <= '0;
      r_last      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_rsp_valid <= w_done ? r_grant : '0;
      r_timeout   <= w_timeout;
      if (r_state == IDLE && w_any) begin
        r_grant <= NUM_REQ'(1) << w_win;
        r_gidx  <= w_win;
        r_beat  <= '0;
        r_wd    <= '0;
      end
      if (w_accept) begin
        r_tx_byte <= bus.req_data[{r_gidx, 3'b000} +: 8];
        r_last    <= bus.req_last[r_gidx];
      end
      if (r_state == START) begin
        r_beat <= r_beat + 8'd1;
        r_wd   <= '0;
      end
      if (w_done) r_rsp_data <= bus.spi_rx_byte;
      if (w_done && !w_release) r_wd <= '0;
      if (w_tick) r_wd <= r_wd + 8'd1;
      if (w_release) begin
        r_grant <= '0;
        r_ptr   <= w_ptr_n;
      end
    end
  end
  assign bus.req_ready    = (r_state == GRANTED) ? r_grant : '0;
  assign bus.grant        = r_grant;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.spi_tx_byte  = r_tx_byte;
  assign bus.spi_tx_start = (r_state == START);
  assign bus.busy         = (r_state != IDLE);
  assign bus.timeout_err  = r_timeout;
endmodule
